// File: rtl/axil_to_wishbone_bridge.sv
// rtl/axil_to_wishbone_bridge.sv - AXI4-Lite responder driving one Wishbone classic master cycle per beat
// Partial-strobe writes become read-modify-write since the target bus has no byte select.
module axil_to_wishbone_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter bit ALIGN_ADDR     = 1'b1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    AWvalid,
  output logic                    AWready,
  input  logic [ADDR_WIDTH-1:0]   AWdata,
  input  logic [2:0]              AWprot,
  input  logic                    Wvalid,
  output logic                    Wready,
  input  logic [DATA_WIDTH-1:0]   Wdata,
  input  logic [DATA_WIDTH/8-1:0] Wstrb,
  output logic                    Bvalid,
  input  logic                    Bready,
  input  logic                    ARvalid,
  output logic                    ARready,
  input  logic [ADDR_WIDTH-1:0]   ARdata,
  input  logic [2:0]              ARprot,
  output logic                    Rvalid,
  input  logic                    RReady,
  output logic [DATA_WIDTH-1:0]   Rdata,
  output logic                    core_cyc_o,
  output logic                    core_stb_o,
  output logic                    core_we_o,
  output logic [ADDR_WIDTH-1:0]   core_addr_o,
  output logic [DATA_WIDTH-1:0]   core_data_o,
  input  logic [DATA_WIDTH-1:0]   core_data_i,
  input  logic                    core_ack_i,
  output logic                    err_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [31:0] TMO_LAST = TMO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ALIGN_ADDR ? ~ADDR_WIDTH'(3) : '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_R_RESP,
    S_RMW_RD,
    S_WR,
    S_B_RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  aw_v_q, aw_v_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_v_q, w_v_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;
  logic                  ar_v_q, ar_v_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic                  last_wr_q, last_wr_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [31:0]           tmo_q, tmo_d;

  logic                  bus_ack;
  logic                  tmo_hit;
  logic                  wr_elig;
  logic                  rd_elig;
  logic                  grant_rd;
  logic [DATA_WIDTH-1:0] merged;
  logic                  unused_prot;

  assign unused_prot = ^{AWprot, ARprot};

  assign AWready     = rst_n & ~aw_v_q;
  assign Wready      = rst_n & ~w_v_q;
  assign ARready     = rst_n & ~ar_v_q;
  assign Bvalid      = (state_q == S_B_RESP);
  assign Rvalid      = (state_q == S_R_RESP);
  assign Rdata       = rdata_q;
  assign core_cyc_o  = cyc_q;
  assign core_stb_o  = cyc_q;
  assign core_we_o   = we_q;
  assign core_addr_o = addr_q & ADDR_MASK;
  assign core_data_o = wdat_q;
  assign err_o       = err_q;

  // An ack only counts while our own cycle is open; stray acks are dropped.
  assign bus_ack  = cyc_q & core_ack_i;
  assign tmo_hit  = TMO_EN && cyc_q && !core_ack_i && (tmo_q == TMO_LAST);
  assign wr_elig  = aw_v_q & w_v_q;
  assign rd_elig  = ar_v_q;
  assign grant_rd = rd_elig && (!wr_elig || last_wr_q);

  always_comb begin
    merged = core_data_i;
    for (int i = 0; i < STRB_W; i++) begin
      if (w_strb_q[i]) merged[8*i +: 8] = w_data_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    aw_v_d    = aw_v_q;
    aw_addr_d = aw_addr_q;
    w_v_d     = w_v_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    ar_v_d    = ar_v_q;
    ar_addr_d = ar_addr_q;
    last_wr_d = last_wr_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    tmo_d     = cyc_q ? tmo_q + 32'd1 : 32'd0;

    if (AWvalid && AWready) begin
      aw_v_d    = 1'b1;
      aw_addr_d = AWdata;
    end
    if (Wvalid && Wready) begin
      w_v_d    = 1'b1;
      w_data_d = Wdata;
      w_strb_d = Wstrb;
    end
    if (ARvalid && ARready) begin
      ar_v_d    = 1'b1;
      ar_addr_d = ARdata;
    end

    case (state_q)
      S_IDLE: begin
        // The round-robin bit only moves when both directions were competing.
        if (grant_rd) begin
          if (wr_elig) last_wr_d = 1'b0;
          state_d = S_RD;
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = ar_addr_q;
        end else if (wr_elig) begin
          if (rd_elig) last_wr_d = 1'b1;
          addr_d = aw_addr_q;
          wdat_d = w_data_q;
          if (w_strb_q == '1) begin
            state_d = S_WR;
            cyc_d   = 1'b1;
            we_d    = 1'b1;
          end else if (w_strb_q == '0) begin
            state_d = S_B_RESP;
          end else begin
            state_d = S_RMW_RD;
            cyc_d   = 1'b1;
            we_d    = 1'b0;
          end
        end
      end
      S_RD: begin
        if (bus_ack) begin
          cyc_d   = 1'b0;
          rdata_d = core_data_i;
          state_d = S_R_RESP;
        end else if (tmo_hit) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          rdata_d = '1;
          state_d = S_R_RESP;
        end
      end
      S_R_RESP: begin
        if (RReady) begin
          ar_v_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_RMW_RD: begin
        if (bus_ack) begin
          cyc_d   = 1'b0;
          wdat_d  = merged;
          we_d    = 1'b1;
          state_d = S_WR;
        end else if (tmo_hit) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_B_RESP;
        end
      end
      S_WR: begin
        // Arriving from RMW_RD the bus is still idle for one cycle; open the write now.
        if (!cyc_q) begin
          cyc_d = 1'b1;
        end else if (bus_ack) begin
          cyc_d   = 1'b0;
          state_d = S_B_RESP;
        end else if (tmo_hit) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_B_RESP;
        end
      end
      S_B_RESP: begin
        if (Bready) begin
          aw_v_d  = 1'b0;
          w_v_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      aw_v_q    <= 1'b0;
      aw_addr_q <= '0;
      w_v_q     <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_v_q    <= 1'b0;
      ar_addr_q <= '0;
      last_wr_q <= 1'b1;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdat_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      tmo_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      aw_v_q    <= aw_v_d;
      aw_addr_q <= aw_addr_d;
      w_v_q     <= w_v_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      ar_v_q    <= ar_v_d;
      ar_addr_q <= ar_addr_d;
      last_wr_q <= last_wr_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

endmodule

// File: tb/tb_axil_to_wishbone_bridge.sv
// tb/tb_axil_to_wishbone_bridge.sv - self-checking bench for axil_to_wishbone_bridge
// Wishbone target model, table vectors, corner sequences and a randomized memory reference model.
module tb_axil_to_wishbone_bridge;

  logic        clk;
  logic        rst_n;
  logic        AWvalid, AWready, Wvalid, Wready, Bvalid, Bready;
  logic        ARvalid, ARready, Rvalid, RReady;
  logic [31:0] AWdata, Wdata, ARdata, Rdata;
  logic [3:0]  Wstrb;
  logic [2:0]  AWprot, ARprot;
  logic        core_cyc_o, core_stb_o, core_we_o, core_ack_i, err_o;
  logic [31:0] core_addr_o, core_data_o, core_data_i;

  axil_to_wishbone_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ALIGN_ADDR(1'b1), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .AWvalid(AWvalid), .AWready(AWready), .AWdata(AWdata), .AWprot(AWprot),
    .Wvalid(Wvalid), .Wready(Wready), .Wdata(Wdata), .Wstrb(Wstrb),
    .Bvalid(Bvalid), .Bready(Bready),
    .ARvalid(ARvalid), .ARready(ARready), .ARdata(ARdata), .ARprot(ARprot),
    .Rvalid(Rvalid), .RReady(RReady), .Rdata(Rdata),
    .core_cyc_o(core_cyc_o), .core_stb_o(core_stb_o), .core_we_o(core_we_o),
    .core_addr_o(core_addr_o), .core_data_o(core_data_o), .core_data_i(core_data_i),
    .core_ack_i(core_ack_i), .err_o(err_o)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pre;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          w_lead;
    logic [31:0] exp_word;
    int          exp_bus;
    logic [31:0] exp_baddr;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_cnt  = 0;
  int ack_lat  = 2;
  bit ack_en   = 1'b1;
  bit stale_ack = 1'b0;
  int slv_cnt  = 0;
  int bus_starts = 0;
  int stab_bad = 0;
  int err_total = 0;
  logic        prev_cyc = 1'b0;
  logic [64:0] prev_bus = '0;
  bus_t        bus_log[$];
  logic [31:0] mem   [logic [31:0]];
  logic [31:0] model [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a * 32'h9E37_79B1;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    return model.exists(a) ? model[a] : init_word(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt++;

  // Wishbone target: acks ack_lat cycles into each cycle, logs every acked access.
  always @(posedge clk) begin
    bus_t e;
    #2;
    if (!rst_n || !core_cyc_o) begin
      core_ack_i = stale_ack;
      slv_cnt = 0;
    end else if (core_ack_i) begin
      core_ack_i = 1'b0;
    end else if (ack_en) begin
      slv_cnt++;
      if (slv_cnt >= ack_lat) begin
        core_ack_i = 1'b1;
        if (core_we_o) mem[core_addr_o] = core_data_o;
        else core_data_i = rd_word(core_addr_o);
        e.we = core_we_o; e.addr = core_addr_o; e.data = core_we_o ? core_data_o : core_data_i;
        bus_log.push_back(e);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n && core_cyc_o && prev_cyc && ({core_we_o, core_addr_o, core_data_o} !== prev_bus)) stab_bad++;
    if (core_stb_o !== core_cyc_o) stab_bad++;
    if (core_cyc_o && !prev_cyc) bus_starts++;
    if (err_o) err_total++;
    prev_cyc = core_cyc_o;
    prev_bus = {core_we_o, core_addr_o, core_data_o};
  end

  task automatic hs_aw(input logic [31:0] a);
    int g = 0;
    AWvalid = 1'b1; AWdata = a;
    while (!AWready && g < 60) begin @(posedge clk); #1; g++; end
    check("awready", 32'(AWready), 32'd1);
    @(posedge clk); #1; AWvalid = 1'b0;
  endtask

  task automatic hs_w(input logic [31:0] d, input logic [3:0] s);
    int g = 0;
    Wvalid = 1'b1; Wdata = d; Wstrb = s;
    while (!Wready && g < 60) begin @(posedge clk); #1; g++; end
    check("wready", 32'(Wready), 32'd1);
    @(posedge clk); #1; Wvalid = 1'b0;
  endtask

  task automatic hs_ar(input logic [31:0] a);
    int g = 0;
    ARvalid = 1'b1; ARdata = a;
    while (!ARready && g < 60) begin @(posedge clk); #1; g++; end
    check("arready", 32'(ARready), 32'd1);
    @(posedge clk); #1; ARvalid = 1'b0;
  endtask

  // w_lead > 0: W presented that many cycles before AW; < 0: AW first.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lead, input int b_delay, output int lat);
    int t0, g;
    t0 = cyc_cnt;
    fork
      begin if (w_lead < 0) begin repeat (-w_lead) @(posedge clk); #1; end hs_w(d, s); end
      begin if (w_lead > 0) begin repeat (w_lead) @(posedge clk); #1; end hs_aw(a); end
    join
    g = 0;
    while (!Bvalid && g < 60) begin @(posedge clk); #1; g++; end
    check("bvalid_seen", 32'(Bvalid), 32'd1);
    lat = cyc_cnt - t0;
    repeat (b_delay) begin @(posedge clk); #1; end
    Bready = 1'b1; @(posedge clk); #1; Bready = 1'b0;
    check("bvalid_once", 32'(Bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [31:0] a, input int r_delay,
                          output logic [31:0] data, output int lat);
    int t0, g, held_bad;
    t0 = cyc_cnt;
    hs_ar(a);
    g = 0;
    while (!Rvalid && g < 60) begin @(posedge clk); #1; g++; end
    check("rvalid_seen", 32'(Rvalid), 32'd1);
    lat = cyc_cnt - t0;
    data = Rdata;
    held_bad = 0;
    repeat (r_delay) begin
      @(posedge clk); #1;
      if (!Rvalid || Rdata !== data) held_bad++;
    end
    check("r_held", 32'(held_bad), 32'd0);
    RReady = 1'b1; @(posedge clk); #1; RReady = 1'b0;
    check("rvalid_drop", 32'(Rvalid), 32'd0);
  endtask

  task automatic arb_pair(input logic [31:0] base, output logic first_we, output logic second_we);
    int g = 0;
    bus_log.delete();
    RReady = 1'b1; Bready = 1'b1;
    fork
      hs_ar(base);
      hs_aw(base + 32'd4);
      hs_w(32'h0BAD_F00D, 4'hF);
    join
    while (bus_log.size() < 2 && g < 60) begin @(posedge clk); #1; g++; end
    repeat (4) begin @(posedge clk); #1; end
    RReady = 1'b0; Bready = 1'b0;
    check("arb_count", 32'(bus_log.size()), 32'd2);
    check("arb_resp_idle", {30'd0, Rvalid, Bvalid}, 32'd0);
    first_we  = (bus_log.size() > 0) ? bus_log[0].we : 1'bx;
    second_we = (bus_log.size() > 1) ? bus_log[1].we : 1'bx;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[6];
    logic [31:0] r, a, ka, d, e, w;
    logic [3:0]  s;
    logic        fw, sw;
    int          lat, s0, e0, cyc_hi, err_hi, lead, nb;

    vecs[0] = '{32'h30, 32'h1122_3344, 32'h0000_AA00, 4'b0010,  0, 32'h1122_AA44, 2, 32'h30};
    vecs[1] = '{32'h20, 32'h0000_0000, 32'hCAFE_BABE, 4'b1111,  3, 32'hCAFE_BABE, 1, 32'h20};
    vecs[2] = '{32'h40, 32'hDEAD_BEEF, 32'h1234_5678, 4'b0000,  0, 32'hDEAD_BEEF, 0, 32'h40};
    vecs[3] = '{32'h44, 32'hA5A5_A5A5, 32'h1122_3344, 4'b1001,  1, 32'h11A5_A544, 2, 32'h44};
    vecs[4] = '{32'h4B, 32'h1234_5678, 32'hFFFF_0000, 4'b1100, -2, 32'hFFFF_5678, 2, 32'h48};
    vecs[5] = '{32'h50, 32'h8765_4321, 32'hAABB_CCDD, 4'b0111,  0, 32'h87BB_CCDD, 2, 32'h50};

    rst_n = 1'b0;
    AWvalid = 0; AWdata = 0; AWprot = 0; Wvalid = 0; Wdata = 0; Wstrb = 0; Bready = 0;
    ARvalid = 0; ARdata = 0; ARprot = 0; RReady = 0; core_data_i = 0; core_ack_i = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {29'd0, AWready, Wready, ARready}, 32'd0);
    check("rst_valid", {29'd0, Bvalid, Rvalid, err_o}, 32'd0);
    check("rst_bus", {29'd0, core_cyc_o, core_stb_o, core_we_o}, 32'd0);
    check("rst_data", Rdata | core_addr_o | core_data_o, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", {29'd0, AWready, Wready, ARready}, 32'd7);

    // Read with slow ack, response held under back-pressure.
    mem[32'h10] = 32'h1234_5678;
    ack_lat = 3; bus_log.delete();
    axi_read(32'h10, 5, r, lat);
    check("t1_rdata", r, 32'h1234_5678);
    check("t1_bus_n", 32'(bus_log.size()), 32'd1);
    if (bus_log.size() > 0) check("t1_bus", {bus_log[0].we, bus_log[0].addr[30:0]}, 32'h10);
    ack_lat = 2;

    // Latencies with ack returned one cycle after stb.
    axi_read(32'h10, 0, r, lat);
    check("lat_read", 32'(lat), 32'd4);
    axi_write(32'h14, 32'h0102_0304, 4'hF, 0, 0, lat);
    check("lat_full_wr", 32'(lat), 32'd4);
    axi_write(32'h14, 32'hFF00_0000, 4'h8, 0, 0, lat);
    check("lat_rmw_wr", 32'(lat), 32'd7);
    check("lat_rmw_mem", rd_word(32'h14), 32'hFF02_0304);

    for (int i = 0; i < 6; i++) begin
      mem[vecs[i].exp_baddr] = vecs[i].pre;
      bus_log.delete();
      s0 = bus_starts;
      axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].w_lead, i % 3, lat);
      check($sformatf("vec%0d_bus_n", i), 32'(bus_starts - s0), 32'(vecs[i].exp_bus));
      if (vecs[i].exp_bus > 0 && bus_log.size() > 0) begin
        check($sformatf("vec%0d_wr_addr", i), bus_log[$].addr, vecs[i].exp_baddr);
        check($sformatf("vec%0d_wr_data", i), bus_log[$].data, vecs[i].exp_word);
      end
      axi_read(vecs[i].addr, 1, r, lat);
      check($sformatf("vec%0d_rdback", i), r, vecs[i].exp_word);
    end

    // Simultaneous read/write: read wins after reset, then write wins the next contest.
    arb_pair(32'h60, fw, sw);
    check("arb1_order", {30'd0, fw, sw}, 32'b01);
    arb_pair(32'h68, fw, sw);
    check("arb2_order", {30'd0, fw, sw}, 32'b10);

    // Read timeout: no ack ever.
    ack_en = 1'b0;
    hs_ar(32'h70);
    cyc_hi = 0; err_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (core_cyc_o) cyc_hi++;
      if (err_o) err_hi++;
    end
    check("tmo_cyc_len", 32'(cyc_hi), 32'd8);
    check("tmo_err_pulse", 32'(err_hi), 32'd1);
    check("tmo_rvalid", 32'(Rvalid), 32'd1);
    check("tmo_rdata", Rdata, 32'hFFFF_FFFF);
    RReady = 1'b1; @(posedge clk); #1; RReady = 1'b0;

    // Write timeout: write abandoned, response still given.
    mem[32'h74] = 32'h0000_0055;
    e0 = err_total;
    axi_write(32'h74, 32'h0000_0099, 4'hF, 0, 0, lat);
    check("tmo_wr_err", 32'(err_total - e0), 32'd1);
    check("tmo_wr_mem", rd_word(32'h74), 32'h0000_0055);
    ack_en = 1'b1;

    // Stray ack while the bus is idle, including the RMW gap cycle.
    mem[32'h78] = 32'h1111_1111;
    s0 = bus_starts;
    stale_ack = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("stale_idle", {29'd0, Rvalid, Bvalid, core_cyc_o}, 32'd0);
    axi_write(32'h78, 32'h0000_2200, 4'b0010, 0, 0, lat);
    stale_ack = 1'b0;
    check("stale_bus_n", 32'(bus_starts - s0), 32'd2);
    check("stale_mem", rd_word(32'h78), 32'h1111_2211);

    // Randomized traffic against a plain memory model.
    mem.delete(); model.delete();
    for (int k = 0; k < 40; k++) begin
      a  = 32'h100 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
      ka = a & ~32'h3;
      ack_lat = int'($urandom_range(1, 4));
      bus_log.delete();
      s0 = bus_starts;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        lead = int'($urandom_range(0, 4)) - 2;
        w = model_word(ka);
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        model[ka] = w;
        nb = (s == 4'h0) ? 0 : ((s == 4'hF) ? 1 : 2);
        axi_write(a, d, s, lead, int'($urandom_range(0, 3)), lat);
        check("rnd_wr_bus_n", 32'(bus_starts - s0), 32'(nb));
        if (nb > 0 && bus_log.size() > 0) begin
          check("rnd_wr_addr", bus_log[$].addr, ka);
          check("rnd_wr_data", bus_log[$].data, w);
        end
      end else begin
        axi_read(a, int'($urandom_range(0, 3)), r, lat);
        check("rnd_rd_data", r, model_word(ka));
        check("rnd_rd_bus_n", 32'(bus_starts - s0), 32'd1);
      end
    end
    ack_lat = 2;
    check("bus_stable", 32'(stab_bad), 32'd0);

    // Asynchronous reset in the middle of a write cycle.
    ack_en = 1'b0;
    fork
      hs_aw(32'h80);
      hs_w(32'h5555_AAAA, 4'hF);
    join
    for (int i = 0; i < 10 && !core_cyc_o; i++) begin @(posedge clk); #1; end
    check("rst_mid_cyc_open", 32'(core_cyc_o), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_async", {29'd0, core_cyc_o, core_stb_o, Bvalid}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ready", {29'd0, AWready, Wready, ARready}, 32'd7);
    check("rst_mid_idle", {29'd0, core_cyc_o, Bvalid, Rvalid}, 32'd0);
    ack_en = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    check("rst_mid_quiet", {30'd0, core_cyc_o, Bvalid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
